// File: rtl/uart_debug_pkg.sv
// uart_debug_pkg: shared FSM encodings and line constants for the debug UART.
// The PARITY state exists only when UART_DEBUG_TX_PARITY_EN is defined.
package uart_debug_pkg;
    localparam int CLKS_PER_BIT_12M_115200 = 104;
    localparam logic LINE_IDLE = 1'b1;
`ifdef UART_DEBUG_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
endpackage

// File: rtl/uart_debug_fifo.sv
// uart_debug_fifo: synchronous byte FIFO with gated push/pop, full/empty flags and occupancy count.
module uart_debug_fifo #(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/uart_debug_tx.sv
// uart_debug_tx: FIFO-buffered 8N1 debug UART transmitter, LSB first.
// Define UART_DEBUG_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_debug_tx
    import uart_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_12M_115200,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    output logic            tx,
    output logic            busy,
    output logic            fifo_full,
    output logic            fifo_empty,
    output logic [ADDR_W:0] fifo_count,
    output logic            overflow,
    output logic            tx_done
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_n;
    logic [15:0] baud, baud_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift, shift_n, fifo_dout;
    logic        pop, last, tx_n;
`ifdef UART_DEBUG_TX_PARITY_EN
    logic        par, par_n;
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    uart_debug_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= LINE_IDLE;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_DEBUG_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx       <= tx_n;
            busy     <= state_n != S_IDLE;
            tx_done  <= state_n == S_STOP && baud_n == BAUD_LAST;
            overflow <= overflow | (wr_en & fifo_full);
`ifdef UART_DEBUG_TX_PARITY_EN
            par      <= par_n;
`endif
        end

    // Outputs are registered from the next-state values so tx lines up with the state it belongs to.
    always_comb begin
        last    = baud == BAUD_LAST;
        state_n = state;
        baud_n  = last ? '0 : baud + 16'd1;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
`ifdef UART_DEBUG_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            S_IDLE: begin
                baud_n = '0;
                pop    = !fifo_empty;
            end
            S_START: if (last) state_n = S_DATA;
            S_DATA: if (last) begin
                shift_n = shift >> 1;
                bit_n   = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = AFTER_DATA;
            end
`ifdef UART_DEBUG_TX_PARITY_EN
            S_PARITY: if (last) state_n = S_STOP;
`endif
            S_STOP: if (last) begin
                state_n = S_IDLE;
                pop     = !fifo_empty;
            end
            default: state_n = S_IDLE;
        endcase
        if (pop) begin
            state_n = S_START;
            shift_n = fifo_dout;
`ifdef UART_DEBUG_TX_PARITY_EN
            par_n   = ^fifo_dout;
`endif
        end
        tx_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? shift_n[0] : LINE_IDLE;
`ifdef UART_DEBUG_TX_PARITY_EN
        if (state_n == S_PARITY) tx_n = par_n;
`endif
    end
endmodule

// File: tb/tb_uart_debug_tx.sv
// tb_uart_debug_tx: directed and random stimulus against a queue/timeline model of the debug UART.
module tb_uart_debug_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int AW = 2;
`ifdef UART_DEBUG_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic tx, busy, fifo_full, fifo_empty, overflow, tx_done;
    logic [AW:0] fifo_count;

    always #5 clk = ~clk;

    uart_debug_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx(tx), .busy(busy),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .overflow(overflow), .tx_done(tx_done)
    );

    int checks = 0, failures = 0;
    logic [7:0] q[$];
    int cyc = 0, free_at = 0, f_start = -1000000, done_cnt = 0;
    logic [7:0] f_byte = 8'h00;
    logic m_ovf = 1'b0;

    // Serial frame: start, 8 data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        free_at = 0;
        f_start = -1000000;
    endtask

    task automatic check_all();
        int k;
        logic act;
        k = cyc - f_start;
        act = k >= 0 && k < FRAME;
        chk("tx", 16'(tx), 16'(act ? frame_bit(f_byte, k / CPB) : 1'b1));
        chk("busy", 16'(busy), 16'(act));
        chk("tx_done", 16'(tx_done), 16'(act && k == FRAME - 1));
        chk("fifo_count", 16'(fifo_count), 16'(q.size()));
        chk("fifo_empty", 16'(fifo_empty), 16'(q.size() == 0));
        chk("fifo_full", 16'(fifo_full), 16'(q.size() == DEPTH));
        chk("overflow", 16'(overflow), 16'(m_ovf));
        if (tx_done === 1'b1) done_cnt++;
    endtask

    task automatic step(input logic we, input logic [7:0] d);
        logic full0;
        wr_en = we;
        wr_data = d;
        @(posedge clk);
        if (reset) model_clear();
        else begin
            full0 = q.size() == DEPTH;
            if (q.size() != 0 && cyc >= free_at) begin
                f_byte = q.pop_front();
                f_start = cyc + 1;
                free_at = cyc + FRAME;
            end
            if (we) begin
                if (full0) m_ovf = 1'b1;
                else q.push_back(d);
            end
        end
        cyc++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        logic hit;
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic hit;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("reset_tx", 16'(tx), 16'h1);
        chk("reset_empty", 16'(fifo_empty), 16'h1);
        reset = 1'b0;
        step(1'b0, 8'h00);

        c0 = cyc;
        step(1'b1, 8'h55);
        chk("p1_empty_c1", 16'(fifo_empty), 16'h0);
        for (int i = 0; i < FRAME + 8; i++) begin
            step(1'b0, 8'h00);
            if (cyc == c0 + 1 + 1) chk("p1_start_c2", 16'(tx), 16'h0);
            if (cyc == c0 + 1 + FRAME) chk("p1_done", 16'(tx_done), 16'h1);
            if (cyc == c0 + 2 + FRAME) chk("p1_busy_low", 16'(busy), 16'h0);
        end

        c0 = cyc;
        step(1'b1, 8'h00);
        chk("p2_count_c1", 16'(fifo_count), 16'h1);
        step(1'b1, 8'hFF);
        chk("p2_count_c2", 16'(fifo_count), 16'h1);
        for (int i = 0; i < 2 * FRAME + 6; i++) begin
            step(1'b0, 8'h00);
            if (cyc == c0 + 2 + FRAME) begin
                chk("p2_gapless_start", 16'(tx), 16'h0);
                chk("p2_count_after_pop", 16'(fifo_count), 16'h0);
            end
        end

        done_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        chk("p3_full", 16'(fifo_full), 16'h1);
        chk("p3_overflow", 16'(overflow), 16'h1);
        for (int i = 0; i < 5 * FRAME + 10; i++) step(1'b0, 8'h00);
        chk("p3_frames", 16'(done_cnt), 16'd5);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
        chk("p4_no_ovf_yet", 16'(overflow), 16'h0);
        hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            if (q.size() == DEPTH && cyc >= free_at) begin
                step(1'b1, 8'hA5);
                chk("p4_count_3", 16'(fifo_count), 16'd3);
                chk("p4_ovf_set", 16'(overflow), 16'h1);
                hit = 1'b1;
            end else step(1'b0, 8'h00);
        end
        chk("p4_pop_reached", 16'(hit), 16'h1);

        for (int i = 0; i < 1500; i++) step($urandom_range(0, 7) == 0, 8'($urandom));

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
        hit = 1'b0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            step(1'b0, 8'h00);
            if (cyc - f_start == 5 * CPB + 1) hit = 1'b1;
        end
        chk("p5_data3_reached", 16'(hit), 16'h1);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("p5_async_tx", 16'(tx), 16'h1);
        chk("p5_async_empty", 16'(fifo_empty), 16'h1);
        chk("p5_async_busy", 16'(busy), 16'h0);
        step(1'b0, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) step(1'b0, 8'h00);

        step(1'b1, 8'h07);
        for (int i = 0; i < FRAME + 8; i++) step(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
